// File: rtl/simple_fpga_cvs_pkg.sv
// rtl/simple_fpga_cvs_pkg.sv - shared sizing constants for the five-channel activity monitor
package simple_fpga_cvs_pkg;

    localparam int NUM_CH          = 5;
    localparam int CVS_SYNC_STAGES = 2;
    localparam int CVS_TIMEOUT     = 16;
    localparam int CNT_W           = $clog2(CVS_TIMEOUT);

    typedef logic [CNT_W-1:0] cvs_cnt_t;

endpackage

// File: rtl/simple_fpga_cvs_if.sv
// rtl/simple_fpga_cvs_if.sv - monitored inputs and alive flags bundled as one port
interface simple_fpga_cvs_if;
    import simple_fpga_cvs_pkg::*;

    logic sig_in [NUM_CH-1:0];
    logic out    [NUM_CH-1:0];

    modport master (output sig_in, input out);
    modport slave  (input sig_in, output out);

endinterface

// File: rtl/simple_fpga_cvs_channel.sv
// rtl/simple_fpga_cvs_channel.sv - one channel: synchroniser, toggle detector, idle counter, alive flag
module cvs_channel
    import simple_fpga_cvs_pkg::*;
#(
    parameter int SYNC_STAGES = CVS_SYNC_STAGES,
    parameter int TIMEOUT     = CVS_TIMEOUT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sig_in,
    output logic alive
);

    localparam int                 W       = $clog2(TIMEOUT);
    localparam logic [W-1:0]       CNT_MAX = W'(TIMEOUT - 1);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic         prev_q;
    logic [W-1:0] cnt_q;
    logic         s;
    logic         tog;

    assign s   = sync_q[SYNC_STAGES-1];
    assign tog = s ^ prev_q;

    // A detected toggle takes priority over an expiring counter in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
            alive  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= s;
            if (tog) begin
                cnt_q <= '0;
                alive <= 1'b1;
            end else if (cnt_q == CNT_MAX) begin
                alive <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/simple_fpga_cvs.sv
// rtl/simple_fpga_cvs.sv - five independent signal-activity monitors with registered alive flags
module simple_fpga_cvs
    import simple_fpga_cvs_pkg::*;
#(
    parameter int SYNC_STAGES = CVS_SYNC_STAGES,
    parameter int TIMEOUT     = CVS_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset_n,
    simple_fpga_cvs_if.slave  cvs
);

    logic alive [NUM_CH-1:0];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        cvs_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .TIMEOUT     (TIMEOUT)
        ) u_ch (
            .clock   (clock),
            .reset_n (reset_n),
            .sig_in  (cvs.sig_in[g]),
            .alive   (alive[g])
        );
    end

    assign cvs.out = alive;

endmodule

// File: tb/tb_simple_fpga_cvs.sv
// tb/tb_simple_fpga_cvs.sv - scoreboard bench for the five-channel activity monitor
module tb_simple_fpga_cvs;
    import simple_fpga_cvs_pkg::*;

    localparam int TO = 16;

    logic       clock    = 1'b0;
    logic       clk_copy = 1'b0;
    logic       reset_n  = 1'b0;
    logic       tie      = 1'b0;
    logic [4:0] sig_drv  = '0;
    logic [4:0] sig_vec;
    logic [4:0] out_vec;

    int n_checks = 0;
    int n_fail   = 0;

    simple_fpga_cvs_if cvs_bus ();

    simple_fpga_cvs #(.SYNC_STAGES(2), .TIMEOUT(TO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .cvs     (cvs_bus)
    );

    assign sig_vec = tie ? {5{clk_copy}} : sig_drv;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_map
        assign cvs_bus.sig_in[g] = sig_vec[g];
        assign out_vec[g]        = cvs_bus.out[g];
    end

    initial forever #5 clock = ~clock;

    // Same frequency as clock, high across every rising edge of clock.
    initial begin
        #4;
        forever begin
            clk_copy = 1'b1;
            #5;
            clk_copy = 1'b0;
            #5;
        end
    end

    task automatic check_eq(input string tag, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: a change sampled at edge m is detected at edge m+2 (out rises there+1 in sample
    // terms, i.e. the detection edge d), and out stays high for edges d .. d+TO-1.
    logic [4:0] h0 = '0, h1 = '0, h2 = '0;
    logic [4:0] exp_v;
    int         d_edge [5] = '{default: -100};
    int         n_edge = 0;
    logic [4:0] exp_q [$];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h0 = '0;
            h1 = '0;
            h2 = '0;
            n_edge = 0;
            for (int i = 0; i < 5; i++) d_edge[i] = -100;
            exp_q.delete();
        end else begin
            n_edge++;
            for (int i = 0; i < 5; i++) begin
                if (h1[i] != h2[i]) d_edge[i] = n_edge;
                exp_v[i] = (n_edge >= d_edge[i]) && (n_edge <= d_edge[i] + TO - 1);
            end
            exp_q.push_back(exp_v);
            h2 = h1;
            h1 = h0;
            h0 = sig_vec;
        end
    end

    always @(negedge clock) begin
        if (!reset_n)
            check_eq("out_in_reset", out_vec, 5'b0);
        else if (exp_q.size() > 0)
            check_eq("out_vs_model", out_vec, exp_q.pop_front());
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clock);
    endtask

    initial begin
        // Reset held while all inputs toggle every cycle.
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            sig_drv = ~sig_drv;
        end
        @(negedge clock);
        sig_drv = '0;
        #2 reset_n = 1'b1;
        tick(5);
        check_eq("idle_after_reset", out_vec, 5'b0);

        // Channel 0 active every 4 clocks; directed check of the 3-edge rise.
        sig_drv[0] = 1'b1;
        tick(2);
        check_eq("pre_rise", out_vec, 5'b0);
        tick(1);
        check_eq("rise_edge3", out_vec, 5'b00001);
        tick(1);
        for (int c = 0; c < 9; c++) begin
            sig_drv[0] = ~sig_drv[0];
            tick(4);
            check_eq("ch0_active", out_vec, 5'b00001);
        end
        sig_drv[0] = ~sig_drv[0];
        tick(18);
        check_eq("pre_fall", out_vec, 5'b00001);
        tick(1);
        check_eq("fall16", out_vec, 5'b0);
        tick(4);

        // Channel 2: second toggle detected on the very edge the counter would expire.
        sig_drv[2] = 1'b1;
        tick(16);
        sig_drv[2] = 1'b0;
        tick(3);
        check_eq("boundary_hold", out_vec, 5'b00100);
        tick(15);
        check_eq("boundary_late", out_vec, 5'b00100);
        tick(1);
        check_eq("boundary_fall", out_vec, 5'b0);
        tick(3);

        // All inputs tied to the clock waveform: one post-reset toggle only.
        @(negedge clock);
        #2 reset_n = 1'b0;
        tie = 1'b1;
        tick(2);
        #2 reset_n = 1'b1;
        tick(6);
        check_eq("tied_alive", out_vec, 5'b11111);

        // Asynchronous clear between edges, then monitoring restarts.
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_eq("async_clear", out_vec, 5'b0);
        #1 reset_n = 1'b1;
        tick(8);
        check_eq("tied_restart", out_vec, 5'b11111);
        tick(16);
        check_eq("tied_timeout", out_vec, 5'b0);
        tick(3);

        // Sparse random activity on all channels, scored every cycle.
        @(negedge clock);
        #2 reset_n = 1'b0;
        tie = 1'b0;
        sig_drv = '0;
        tick(2);
        #2 reset_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            for (int i = 0; i < 5; i++)
                if ($urandom_range(0, 11) == 0) sig_drv[i] = ~sig_drv[i];
        end
        tick(25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
